// File: rtl/lcd_mode_sched_if.sv
// Handshake bundle between the LCD mode scheduler and its environment:
// raw keys, vsync and auto enable in; display-mode select and status out.
interface lcd_mode_sched_if;
  logic       key_next;
  logic       key_prev;
  logic       lcd_vsync;
  logic       auto_en;
  logic [3:0] lcd_dis_mode;
  logic       mode_strobe;
  logic       req_pending;

  modport master (
    output key_next, key_prev, lcd_vsync, auto_en,
    input  lcd_dis_mode, mode_strobe, req_pending
  );
  modport slave (
    input  key_next, key_prev, lcd_vsync, auto_en,
    output lcd_dis_mode, mode_strobe, req_pending
  );
endinterface

// File: rtl/lcd_mode_sched.sv
// Display-mode scheduler: debounced next/prev keys (plus the auto-cycle timer when
// LCD_MODE_AUTO_CYCLE_EN is defined) change the mode only at a vsync falling edge.
module lcd_key_debounce #(
  parameter int DEBOUNCE_CYC = 50000,
  parameter int CNT_W        = 16
) (
  input  logic lcd_clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_press
);
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_st_e;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       r_sync;
  db_st_e           r_st;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic             w_lvl;

  assign w_lvl   = r_sync[1];
  assign o_press = r_press;

  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_st    <= RELEASED;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_key};
      r_press <= 1'b0;
      case (r_st)
        RELEASED: begin
          r_cnt <= '0;
          if (w_lvl) r_st <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!w_lvl) begin
            r_st  <= RELEASED;
            r_cnt <= '0;
          end else if (r_cnt == LAST) begin
            r_st    <= PRESSED;
            r_cnt   <= '0;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESSED: begin
          r_cnt <= '0;
          if (!w_lvl) r_st <= RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          // a bounce back high returns to PRESSED without a second press pulse
          if (w_lvl) begin
            r_st  <= PRESSED;
            r_cnt <= '0;
          end else if (r_cnt == LAST) begin
            r_st  <= RELEASED;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_st <= RELEASED;
      endcase
    end
  end
endmodule

module lcd_mode_sched #(
  parameter int NUM_MODES    = 14,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int AUTO_FRAMES  = 120,
  parameter int CNT_W        = 16
) (
  input logic              lcd_clk,
  input logic              rst_n,
  lcd_mode_sched_if.slave  bus
);
  localparam int              NK    = 2;
  localparam logic [3:0]      LASTM = 4'(NUM_MODES - 1);

  logic [NK-1:0] w_key_raw;
  logic [NK-1:0] w_press;
  logic          w_frame_start;
  logic          w_key_req;
  logic          w_key_dir;
  logic          w_auto_fire;
  logic          w_apply;
  logic          w_apply_dir;

  logic          r_vs_d;
  logic          r_valid;
  logic          r_dir;
  logic [3:0]    r_mode;
  logic          r_strobe;

  // bit 0 = next, bit 1 = prev
  assign w_key_raw = {bus.key_prev, bus.key_next};

  lcd_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_db [NK-1:0] (
    .lcd_clk (lcd_clk),
    .rst_n   (rst_n),
    .i_key   (w_key_raw),
    .o_press (w_press)
  );

  assign w_frame_start = r_vs_d & ~bus.lcd_vsync;
  // simultaneous next+prev pulses cancel
  assign w_key_req     = ^w_press;
  assign w_key_dir     = w_press[1];

`ifdef LCD_MODE_AUTO_CYCLE_EN
  localparam int AF_W = $clog2(AUTO_FRAMES + 1);
  logic [AF_W-1:0] r_auto_cnt;

  assign w_auto_fire = bus.auto_en & w_frame_start &
                       (r_auto_cnt == AF_W'(AUTO_FRAMES - 1));

  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n)                          r_auto_cnt <= '0;
    else if (!bus.auto_en)               r_auto_cnt <= '0;
    else if (w_frame_start && r_valid)   r_auto_cnt <= '0;
    else if (w_frame_start)              r_auto_cnt <= w_auto_fire ? '0 : r_auto_cnt + 1'b1;
  end
`else
  logic w_unused_auto;
  assign w_unused_auto = bus.auto_en;
  assign w_auto_fire   = 1'b0;
`endif

  // Auto requests only arise on a frame boundary, so they are applied at once
  // when nothing is pending and are dropped when a key request owns the slot.
  assign w_apply     = w_frame_start & (r_valid | (w_auto_fire & ~w_key_req));
  assign w_apply_dir = r_valid & r_dir;

  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d   <= 1'b1;
      r_valid  <= 1'b0;
      r_dir    <= 1'b0;
      r_mode   <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_vs_d   <= bus.lcd_vsync;
      r_strobe <= 1'b0;
      if (w_apply) begin
        r_strobe <= 1'b1;
        if (!w_apply_dir) r_mode <= (r_mode == LASTM) ? 4'd0 : r_mode + 4'd1;
        else              r_mode <= (r_mode == 4'd0) ? LASTM : r_mode - 4'd1;
      end
      if (w_key_req) begin
        r_valid <= 1'b1;
        r_dir   <= w_key_dir;
      end else if (w_frame_start && r_valid) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.lcd_dis_mode = r_mode;
  assign bus.mode_strobe  = r_strobe;
  assign bus.req_pending  = r_valid;
endmodule

// File: tb/tb_lcd_mode_sched.sv
// Directed bench for lcd_mode_sched: DEBOUNCE_CYC=8, AUTO_FRAMES=3, vsync falls every 100 cycles.
module tb_lcd_mode_sched;
  logic clk = 1'b0;
  logic rst_n;
  int   vs_cnt;
  int   n_chk = 0;
  int   n_err = 0;

  lcd_mode_sched_if bus();

  lcd_mode_sched #(.NUM_MODES(14), .DEBOUNCE_CYC(8), .AUTO_FRAMES(3), .CNT_W(16)) dut (
    .lcd_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // vsync low for 4 cycles out of every 100, falling when vs_cnt wraps to 0
  initial begin
    vs_cnt        = 1;
    bus.lcd_vsync = 1'b1;
    forever begin
      @(posedge clk); #1;
      vs_cnt        = (vs_cnt == 99) ? 0 : vs_cnt + 1;
      bus.lcd_vsync = (vs_cnt >= 4);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // returns in the frame_start cycle (vsync just fell)
  task automatic wait_fall();
    int n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (vs_cnt != 0 && n < 250);
    if (vs_cnt != 0) check("vsync_wait", vs_cnt, 0);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input logic nx, input logic pv);
    bus.key_next = nx;
    bus.key_prev = pv;
    cyc(20);
    bus.key_next = 1'b0;
    bus.key_prev = 1'b0;
    cyc(15);
  endtask

  // press early in a frame, return one cycle after the following frame_start
  task automatic step_press(input logic nx, input logic pv);
    wait_fall();
    cyc(5);
    press(nx, pv);
    wait_fall();
    cyc(1);
  endtask

  initial begin
    int n_stb;
    rst_n        = 1'b0;
    bus.key_next = 1'b0;
    bus.key_prev = 1'b0;
    bus.auto_en  = 1'b0;
    cyc(3);
    check("rst_mode", bus.lcd_dis_mode, 0);
    check("rst_pend", bus.req_pending, 0);
    rst_n = 1'b1;
    cyc(1);
    check("rel_mode", bus.lcd_dis_mode, 0);
    check("rel_strobe", bus.mode_strobe, 0);
    check("rel_pend", bus.req_pending, 0);
    n_stb = 0;
    repeat (300) begin cyc(1); n_stb += int'(bus.mode_strobe); end
    check("idle_strobes", n_stb, 0);

    // glitch reject then a real press
    wait_fall();
    cyc(5);
    bus.key_next = 1'b1;
    cyc(5);
    bus.key_next = 1'b0;
    cyc(20);
    check("glitch_pend", bus.req_pending, 0);
    press(1'b1, 1'b0);
    check("press_pend", bus.req_pending, 1);
    check("press_mode_hold", bus.lcd_dis_mode, 0);
    wait_fall();
    check("pre_apply_mode", bus.lcd_dis_mode, 0);
    cyc(1);
    check("apply_mode", bus.lcd_dis_mode, 1);
    check("apply_strobe", bus.mode_strobe, 1);
    cyc(1);
    check("strobe_single", bus.mode_strobe, 0);
    check("apply_pend_clr", bus.req_pending, 0);

    // wrap both directions
    for (int i = 0; i < 12; i++) step_press(1'b1, 1'b0);
    check("wrap_up13", bus.lcd_dis_mode, 13);
    step_press(1'b1, 1'b0);
    check("wrap_to0", bus.lcd_dis_mode, 0);
    step_press(1'b0, 1'b1);
    check("wrap_prev13", bus.lcd_dis_mode, 13);

    // last press wins within a frame
    wait_fall();
    cyc(5);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("ovr_pend", bus.req_pending, 1);
    wait_fall();
    cyc(1);
    check("ovr_mode", bus.lcd_dis_mode, 12);
    check("ovr_strobe", bus.mode_strobe, 1);

    // simultaneous next+prev cancel
    wait_fall();
    cyc(5);
    press(1'b1, 1'b1);
    check("simul_pend", bus.req_pending, 0);
    wait_fall();
    cyc(1);
    check("simul_strobe", bus.mode_strobe, 0);
    check("simul_mode", bus.lcd_dis_mode, 12);

`ifdef LCD_MODE_AUTO_CYCLE_EN
    wait_fall();
    cyc(1);
    bus.auto_en = 1'b1;
    for (int f = 1; f <= 9; f++) begin
      wait_fall();
      cyc(1);
      if (f == 3) check("auto_f3", bus.lcd_dis_mode, 13);
      if (f == 6) check("auto_f6", bus.lcd_dis_mode, 0);
      if (f == 9) check("auto_f9", bus.lcd_dis_mode, 1);
      if (f % 3 != 0) check("auto_nostrobe", bus.mode_strobe, 0);
    end
    wait_fall();
    cyc(5);
    press(1'b0, 1'b1);
    wait_fall();
    cyc(1);
    check("auto_key_mode", bus.lcd_dis_mode, 0);
    check("auto_key_strobe", bus.mode_strobe, 1);
    wait_fall();
    wait_fall();
    cyc(1);
    check("auto_restart_hold", bus.lcd_dis_mode, 0);
    wait_fall();
    cyc(1);
    check("auto_restart_step", bus.lcd_dis_mode, 1);
    bus.auto_en = 1'b0;
`else
    bus.auto_en = 1'b1;
    n_stb = 0;
    repeat (950) begin cyc(1); n_stb += int'(bus.mode_strobe); end
    check("noauto_strobes", n_stb, 0);
    check("noauto_mode", bus.lcd_dis_mode, 12);
    bus.auto_en = 1'b0;
`endif

    // reset with a pending request
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    check("rst2_mode", bus.lcd_dis_mode, 0);
    for (int i = 0; i < 5; i++) step_press(1'b1, 1'b0);
    check("pre_rst_mode", bus.lcd_dis_mode, 5);
    wait_fall();
    cyc(5);
    press(1'b1, 1'b0);
    check("pre_rst_pend", bus.req_pending, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_mode", bus.lcd_dis_mode, 0);
    check("midrst_pend", bus.req_pending, 0);
    check("midrst_strobe", bus.mode_strobe, 0);
    cyc(2);
    rst_n = 1'b1;
    wait_fall();
    cyc(1);
    check("post_rst_strobe", bus.mode_strobe, 0);
    check("post_rst_mode", bus.lcd_dis_mode, 0);
    check("post_rst_pend", bus.req_pending, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
